// File: rtl/predictor_update_sched_if.sv
// Resolved-branch update lanes and the PHT/BTB write port of predictor_update_sched.
interface predictor_update_sched_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 10
);
  logic             upd0_valid;
  logic [PC_W-1:0]  upd0_pc;
  logic             upd0_taken;
  logic [PC_W-1:0]  upd0_target;
  logic [1:0]       upd0_state;
  logic             upd0_ready;
  logic             upd1_valid;
  logic [PC_W-1:0]  upd1_pc;
  logic             upd1_taken;
  logic [PC_W-1:0]  upd1_target;
  logic [1:0]       upd1_state;
  logic             upd1_ready;
  logic             pht_we;
  logic [IDX_W-1:0] pht_waddr;
  logic [1:0]       pht_wdata;
  logic             btb_we;
  logic [PC_W-1:0]  btb_wpc;
  logic [PC_W-1:0]  btb_wtarget;
  logic             btb_clr;
  logic             init_busy;

  modport slave (
    input  upd0_valid, upd0_pc, upd0_taken, upd0_target, upd0_state,
    input  upd1_valid, upd1_pc, upd1_taken, upd1_target, upd1_state,
    output upd0_ready, upd1_ready,
    output pht_we, pht_waddr, pht_wdata, btb_we, btb_wpc, btb_wtarget, btb_clr, init_busy
  );

  modport master (
    output upd0_valid, upd0_pc, upd0_taken, upd0_target, upd0_state,
    output upd1_valid, upd1_pc, upd1_taken, upd1_target, upd1_state,
    input  upd0_ready, upd1_ready,
    input  pht_we, pht_waddr, pht_wdata, btb_we, btb_wpc, btb_wtarget, btb_clr, init_busy
  );
endinterface

// File: rtl/predictor_update_sched.sv
// Branch predictor table write scheduler: PHT init walk, then in-order dual-lane update queue.
// Optional macro PRED_UPD_BYPASS_EN: lane0 writes through in its accept cycle when the queue is empty.
module predictor_update_sched #(
  parameter int PC_W    = 32,
  parameter int IDX_W   = 10,
  parameter int Q_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  predictor_update_sched_if.slave bus
);
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] addr;
    logic [1:0]       st;
    logic             taken;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  target;
  } entry_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             init_we;
  logic             init_clr;
  logic [IDX_W-1:0] init_addr;
  logic             busy;

  entry_t           mem [Q_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             ready0, ready1, push0, push1, enq0, enq1, pop, byp;
  logic [CNT_W:0]   lane1_need;
  entry_t           e0, e1, out_e;
  logic             out_v;

  function automatic logic [1:0] sat_next(input logic [1:0] st, input logic taken);
    if (taken) return (st == 2'b11) ? 2'b11 : st + 2'b01;
    else       return (st == 2'b00) ? 2'b00 : st - 2'b01;
  endfunction

  function automatic entry_t mk_entry(input logic [PC_W-1:0] pc, input logic taken,
                                      input logic [PC_W-1:0] target, input logic [1:0] st);
    entry_t e;
    e.addr   = pc[IDX_W+2:3];
    e.st     = sat_next(st, taken);
    e.taken  = taken;
    e.pc     = pc;
    e.target = target;
    return e;
  endfunction

  always_comb begin
    e0         = mk_entry(bus.upd0_pc, bus.upd0_taken, bus.upd0_target, bus.upd0_state);
    e1         = mk_entry(bus.upd1_pc, bus.upd1_taken, bus.upd1_target, bus.upd1_state);
    // readys look only at the registered count, so a same-cycle pop never frees a slot early
    lane1_need = {1'b0, count} + {{CNT_W{1'b0}}, bus.upd0_valid};
    ready0     = !busy && (count <= CNT_W'(Q_DEPTH - 1));
    ready1     = !busy && (lane1_need <= (CNT_W + 1)'(Q_DEPTH - 1));
    push0      = bus.upd0_valid && ready0;
    push1      = bus.upd1_valid && ready1;
    pop        = (count != '0);
`ifdef PRED_UPD_BYPASS_EN
    byp        = push0 && (count == '0);
`else
    byp        = 1'b0;
`endif
    enq0       = push0 && !byp;
    enq1       = push1;
    out_v      = byp || pop;
    out_e      = byp ? e0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (enq0) mem[wr_ptr] <= e0;
    if (enq1) mem[wr_ptr + PTR_W'(enq0)] <= e1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_INIT;
      idx       <= '0;
      init_we   <= 1'b0;
      init_clr  <= 1'b0;
      init_addr <= '0;
      busy      <= 1'b1;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_we   <= 1'b1;
          init_addr <= idx;
          init_clr  <= (idx == '0);
          idx       <= idx + 1'b1;
          if (idx == '1) state <= S_RUN;
        end
        S_RUN: begin
          init_we  <= 1'b0;
          init_clr <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= S_INIT;
      endcase
      wr_ptr <= wr_ptr + PTR_W'(enq0) + PTR_W'(enq1);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(enq0) + CNT_W'(enq1) - CNT_W'(pop);
    end
  end

  always_comb begin
    bus.upd0_ready  = ready0;
    bus.upd1_ready  = ready1;
    bus.pht_we      = init_we || out_v;
    bus.pht_waddr   = init_we ? init_addr : out_e.addr;
    bus.pht_wdata   = init_we ? 2'b01 : out_e.st;
    bus.btb_we      = out_v && out_e.taken;
    bus.btb_wpc     = out_e.pc;
    bus.btb_wtarget = out_e.target;
    bus.btb_clr     = init_clr;
    bus.init_busy   = busy;
  end
endmodule

// File: tb/tb_predictor_update_sched.sv
// Scoreboard bench for predictor_update_sched (IDX_W=4, Q_DEPTH=4); honours PRED_UPD_BYPASS_EN.
module tb_predictor_update_sched;
  localparam int PC_W = 32;
  localparam int IDX_W = 4;
`ifdef PRED_UPD_BYPASS_EN
  localparam int LAT = 0;
  localparam logic BYP = 1'b1;
`else
  localparam int LAT = 1;
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic [1:0]  st;
    logic [3:0]  eaddr;
    logic [1:0]  edata;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [1:0]  data;
    logic        btb_we;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        clr;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  predictor_update_sched_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bus ();

  predictor_update_sched #(.PC_W(PC_W), .IDX_W(IDX_W), .Q_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.pht_we === 1'b1 || bus.btb_we === 1'b1 || bus.btb_clr === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: cyc=%0d we=%b addr=%h data=%b btb_we=%b clr=%b, none required",
                 cyc, bus.pht_we, bus.pht_waddr, bus.pht_wdata, bus.btb_we, bus.btb_clr);
      end else begin
        exp_t e;
        logic ok;
        e  = sb.pop_front();
        ok = (bus.pht_we === 1'b1) && (bus.pht_waddr === e.addr) && (bus.pht_wdata === e.data) &&
             (bus.btb_we === e.btb_we) && (bus.btb_clr === e.clr);
        if (e.btb_we && (bus.btb_wpc !== e.pc || bus.btb_wtarget !== e.tgt)) ok = 1'b0;
        if (e.cyc >= 0 && cyc != e.cyc) ok = 1'b0;
        if (!ok) begin
          errors++;
          $display("FAIL write: cyc=%0d we=%b addr=%h data=%b btb_we=%b pc=%h tgt=%h clr=%b | required cyc=%0d addr=%h data=%b btb_we=%b pc=%h tgt=%h clr=%b",
                   cyc, bus.pht_we, bus.pht_waddr, bus.pht_wdata, bus.btb_we, bus.btb_wpc,
                   bus.btb_wtarget, bus.btb_clr, e.cyc, e.addr, e.data, e.btb_we, e.pc, e.tgt, e.clr);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic push_exp(input vec_t v, input int lat);
    exp_t e;
    e.addr   = v.eaddr;
    e.data   = v.edata;
    e.btb_we = v.taken;
    e.pc     = v.pc;
    e.tgt    = v.tgt;
    e.clr    = 1'b0;
    e.cyc    = (lat >= 0) ? cyc + lat : -1;
    sb.push_back(e);
  endtask

  task automatic drive0(input vec_t v, input logic vld);
    bus.upd0_valid  = vld;
    bus.upd0_pc     = v.pc;
    bus.upd0_taken  = v.taken;
    bus.upd0_target = v.tgt;
    bus.upd0_state  = v.st;
  endtask

  task automatic drive1(input vec_t v, input logic vld);
    bus.upd1_valid  = vld;
    bus.upd1_pc     = v.pc;
    bus.upd1_taken  = v.taken;
    bus.upd1_target = v.tgt;
    bus.upd1_state  = v.st;
  endtask

  // call at posedge+1; holds each lane until accepted, returns at posedge+1
  task automatic send_pair(input vec_t a, input logic va, input vec_t b, input logic vb, input int lat);
    logic p0, p1, a0, a1;
    int n;
    p0 = va;
    p1 = vb;
    n  = 0;
    while ((p0 || p1) && n < 50) begin
      drive0(a, p0);
      drive1(b, p1);
      #2;
      a0 = p0 && bus.upd0_ready;
      a1 = p1 && bus.upd1_ready;
      if (a0) push_exp(a, lat);
      if (a1) push_exp(b, lat);
      @(posedge clk); #1;
      if (a0) p0 = 1'b0;
      if (a1) p1 = 1'b0;
      n++;
    end
    bus.upd0_valid = 1'b0;
    bus.upd1_valid = 1'b0;
    if (p0 || p1) chk("accept_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_reset();
    int r;
    rst_n = 1'b0;
    bus.upd0_valid = 1'b0;
    bus.upd1_valid = 1'b0;
    @(negedge clk); #1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init_busy", 32'(bus.init_busy), 32'd1);
    chk("rst_ready0", 32'(bus.upd0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.upd1_ready), 32'd0);
    chk("rst_pht_we", 32'(bus.pht_we), 32'd0);
    rst_n = 1'b1;
    r = cyc;
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.addr = 4'(i); e.data = 2'b01; e.btb_we = 1'b0; e.pc = '0; e.tgt = '0;
      e.clr = (i == 0); e.cyc = r + 1 + i;
      sb.push_back(e);
    end
    for (int i = 0; i < 40 && bus.init_busy !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    chk("init_busy_fall_cycle", 32'(cyc - r), 32'd17);
    chk("init_done_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  vec_t t1, sat0, sat1, l1a, nt1, b[6], s0, s1, r[4], nul;

  initial begin
    nul  = '{32'h0, 1'b0, 32'h0, 2'b00, 4'h0, 2'b00};
    t1   = '{32'h1C008, 1'b1, 32'h1C100, 2'b01, 4'h1, 2'b10};
    sat0 = '{32'h88,  1'b1, 32'h300, 2'b11, 4'h1, 2'b11};
    sat1 = '{32'h1F0, 1'b0, 32'h0,   2'b00, 4'hE, 2'b00};
    l1a  = '{32'h28,  1'b1, 32'h500, 2'b10, 4'h5, 2'b11};
    nt1  = '{32'h30,  1'b0, 32'h0,   2'b10, 4'h6, 2'b01};
    b[0] = '{32'h100, 1'b1, 32'h900, 2'b10, 4'h0, 2'b11};
    b[1] = '{32'h108, 1'b0, 32'h0,   2'b01, 4'h1, 2'b00};
    b[2] = '{32'h110, 1'b1, 32'hA00, 2'b00, 4'h2, 2'b01};
    b[3] = '{32'h118, 1'b0, 32'h0,   2'b11, 4'h3, 2'b10};
    b[4] = '{32'h120, 1'b1, 32'hB00, 2'b01, 4'h4, 2'b10};
    b[5] = '{32'h128, 1'b0, 32'h0,   2'b10, 4'h5, 2'b01};
    s0   = '{32'h40,  1'b1, 32'h600, 2'b01, 4'h8, 2'b10};
    s1   = '{32'h44,  1'b1, 32'h700, 2'b01, 4'h8, 2'b10};
    r[0] = '{32'h200, 1'b1, 32'hC00, 2'b01, 4'h0, 2'b10};
    r[1] = '{32'h208, 1'b0, 32'h0,   2'b10, 4'h1, 2'b01};
    r[2] = '{32'h210, 1'b1, 32'hD00, 2'b11, 4'h2, 2'b11};
    r[3] = '{32'h218, 1'b0, 32'h0,   2'b00, 4'h3, 2'b00};
    drive0(nul, 1'b0);
    drive1(nul, 1'b0);

    @(posedge clk); #1;
    do_reset();

    send_pair(t1, 1'b1, nul, 1'b0, LAT);
    send_pair(sat0, 1'b1, sat1, 1'b1, -1);
    send_pair(nul, 1'b0, l1a, 1'b1, -1);
    send_pair(nt1, 1'b1, nul, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;

    // burst: both lanes valid three cycles; lane1 must back off once the count reaches 3
    drive0(b[0], 1'b1); drive1(b[1], 1'b1); #2;
    chk("burst_c1_ready0", 32'(bus.upd0_ready), 32'd1);
    chk("burst_c1_ready1", 32'(bus.upd1_ready), 32'd1);
    push_exp(b[0], -1); push_exp(b[1], -1);
    @(posedge clk); #1;
    drive0(b[2], 1'b1); drive1(b[3], 1'b1); #2;
    chk("burst_c2_ready1", 32'(bus.upd1_ready), 32'd1);
    push_exp(b[2], -1); push_exp(b[3], -1);
    @(posedge clk); #1;
    drive0(b[4], 1'b1); drive1(b[5], 1'b1); #2;
    chk("burst_c3_ready0", 32'(bus.upd0_ready), 32'd1);
    chk("burst_c3_ready1", 32'(bus.upd1_ready), 32'(BYP));
    push_exp(b[4], -1);
    if (bus.upd1_ready) push_exp(b[5], -1);
    @(posedge clk); #1;
    if (!BYP) begin
      drive0(nul, 1'b0); #2;
      chk("burst_c4_ready1", 32'(bus.upd1_ready), 32'd1);
      push_exp(b[5], -1);
      @(posedge clk); #1;
    end
    drive0(nul, 1'b0); drive1(nul, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("burst_drained", 32'(sb.size()), 32'd0);

    send_pair(s0, 1'b1, s1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;

    // reset with entries still queued: unwritten entries are dropped, INIT restarts at 0
    send_pair(r[0], 1'b1, r[1], 1'b1, -1);
    send_pair(r[2], 1'b1, r[3], 1'b1, -1);
    do_reset();

    repeat (6) @(posedge clk);
    #1;
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
